// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: binary load -> 14-cycle double-dabble -> commit; outputs registered, one cycle behind the digit tick.
// i_load is ignored while o_busy; leading-zero blanking enabled by FND_BLANK_LEADING_ZERO_EN.
module fnd_scan_controller #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_dp,
  output logic        o_busy,
  output logic [3:0]  o_fndSelect,
  output logic [7:0]  o_fndFont
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [7:0] FONT_RST = (SEG_ACTIVE_LOW != 0) ? 8'hC0 : 8'h3F;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  logic [1:0]    r_state;
  logic [13:0]   r_bin;
  logic [15:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic [15:0]   r_disp;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;

  logic          w_tick;
  logic [15:0]   w_bcd_adj;
  logic [3:0]    w_nib;
  logic [7:0]    w_seg;
  logic          w_blank;
  logic [7:0]    w_font_al;
  logic [7:0]    w_font;

  assign o_busy = (r_state != ST_IDLE);
  assign w_tick = (r_pre == PRE_MAX);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[n*4 +: 4] >= 4'd5) w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_bin   <= (i_value > 14'd9999) ? 14'd9999 : i_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd13) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // whole 16-bit register in one edge so the scan never sees a half-updated value
          r_disp  <= r_bcd;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  always_comb begin
    w_nib = r_disp[{r_idx, 2'b00} +: 4];
    case (w_nib)
      4'd0:    w_seg = 8'hC0;
      4'd1:    w_seg = 8'hF9;
      4'd2:    w_seg = 8'hA4;
      4'd3:    w_seg = 8'hB0;
      4'd4:    w_seg = 8'h99;
      4'd5:    w_seg = 8'h92;
      4'd6:    w_seg = 8'h82;
      4'd7:    w_seg = 8'hF8;
      4'd8:    w_seg = 8'h80;
      4'd9:    w_seg = 8'h90;
      default: w_seg = 8'hFF;
    endcase
  end

`ifdef FND_BLANK_LEADING_ZERO_EN
  always_comb begin
    case (r_idx)
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      2'd2:    w_blank = (r_disp[15:8] == 8'd0);
      2'd1:    w_blank = (r_disp[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_font_al = w_blank ? 8'hFF : w_seg;
    if (i_dp[r_idx]) w_font_al[7] = 1'b0;
    w_font = (SEG_ACTIVE_LOW != 0) ? w_font_al : ~w_font_al;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fndSelect <= 4'b0001;
      o_fndFont   <= FONT_RST;
    end else begin
      o_fndSelect <= 4'b0001 << r_idx;
      o_fndFont   <= w_font;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller with an 8 Hz clock / 2 Hz scan (4 cycles per digit); model built from decimal arithmetic.
module tb_fnd_scan_controller;

  localparam int DIV = 4;
  localparam logic [7:0] LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] i_value = '0;
  logic        i_load = 1'b0;
  logic [3:0]  i_dp = '0;
  logic        o_busy;
  logic [3:0]  o_fndSelect;
  logic [7:0]  o_fndFont;

  int checks = 0;
  int failures = 0;

  fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(2), .SEG_ACTIVE_LOW(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(i_value), .i_load(i_load), .i_dp(i_dp),
    .o_busy(o_busy), .o_fndSelect(o_fndSelect), .o_fndFont(o_fndFont)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_font(int value, logic [3:0] dp, int idx);
    int v, p, digit;
    logic blank;
    logic [7:0] f;
    v = (value > 9999) ? 9999 : value;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    digit = (v / p) % 10;
    blank = 1'b0;
`ifdef FND_BLANK_LEADING_ZERO_EN
    blank = (idx > 0) && (v < p);
`endif
    f = blank ? 8'hFF : LUT[digit];
    if (dp[idx]) f[7] = 1'b0;
    return f;
  endfunction

  // Pulse a load, then count the samples with o_busy high.
  task automatic run_conversion(input logic [13:0] v, output int busy_cycles, output logic rose);
    @(negedge clk);
    i_value = v;
    i_load  = 1'b1;
    @(negedge clk);
    rose   = o_busy;
    i_load = 1'b0;
    busy_cycles = 0;
    while (o_busy && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  // Record the font shown for each digit position, bounded per digit.
  task automatic capture_fonts(output logic [31:0] fonts, output logic ok);
    logic [3:0] want;
    logic found;
    fonts = '0;
    ok = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      want  = 4'b0001 << d;
      found = 1'b0;
      for (int n = 0; n < 4 * DIV + 4; n++) begin
        if (o_fndSelect === want) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!found) ok = 1'b0;
      fonts[d*8 +: 8] = o_fndFont;
    end
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    int last_change, n_changes;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_fndSelect !== 4'b0001) begin failures++; $display("FAIL reset_select got=%b exp=0001", o_fndSelect); end
    checks++; if (o_fndFont !== 8'hC0) begin failures++; $display("FAIL reset_font got=%h exp=c0", o_fndFont); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    rst_n = 1'b1;
    prev = 4'b0001;
    last_change = 0;
    n_changes = 0;
    for (int c = 1; c <= 5 * DIV + 1; c++) begin
      @(negedge clk);
      if (o_fndSelect !== prev) begin
        n_changes++;
        checks++;
        if (o_fndSelect !== {prev[2:0], prev[3]}) begin
          failures++; $display("FAIL scan_order got=%b exp=%b", o_fndSelect, {prev[2:0], prev[3]});
        end
        checks++;
        if (c - last_change !== ((n_changes == 1) ? DIV + 1 : DIV)) begin
          failures++; $display("FAIL scan_interval got=%0d exp=%0d", c - last_change, (n_changes == 1) ? DIV + 1 : DIV);
        end
        last_change = c;
        prev = o_fndSelect;
      end
    end
    checks++; if (n_changes !== 5) begin failures++; $display("FAIL scan_steps got=%0d exp=5", n_changes); end
  endtask

  task automatic test_conversion(input int v, input logic [3:0] dp, input string name);
    int bc;
    logic rose, ok;
    logic [31:0] fonts;
    i_dp = dp;
    run_conversion(v[13:0], bc, rose);
    checks++; if (rose !== 1'b1) begin failures++; $display("FAIL %s busy_rise got=%b exp=1", name, rose); end
    checks++; if (bc !== 15) begin failures++; $display("FAIL %s busy_len got=%0d exp=15", name, bc); end
    capture_fonts(fonts, ok);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!ok || fonts[d*8 +: 8] !== exp_font(v, dp, d)) begin
        failures++; $display("FAIL %s digit%0d got=%h exp=%h ok=%b", name, d, fonts[d*8 +: 8], exp_font(v, dp, d), ok);
      end
    end
  endtask

  task automatic test_random();
    int v;
    logic [3:0] dp;
    for (int i = 0; i < 8; i++) begin
      v  = $urandom_range(0, 16383);
      dp = 4'($urandom_range(0, 15));
      test_conversion(v, dp, "random");
    end
  endtask

  task automatic test_ignored_load();
    int cnt;
    logic ok;
    logic [31:0] fonts;
    i_dp = 4'b0000;
    @(negedge clk);
    i_value = 14'd42;
    i_load  = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    cnt = 0;
    while (o_busy && cnt < 40) begin
      cnt++;
      if (cnt == 3) begin i_value = 14'd5555; i_load = 1'b1; end
      if (cnt == 12) i_load = 1'b0;
      @(negedge clk);
    end
    checks++; if (cnt !== 15) begin failures++; $display("FAIL ignored_busy_len got=%0d exp=15", cnt); end
    capture_fonts(fonts, ok);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!ok || fonts[d*8 +: 8] !== exp_font(42, 4'b0000, d)) begin
        failures++; $display("FAIL ignored_digit%0d got=%h exp=%h", d, fonts[d*8 +: 8], exp_font(42, 4'b0000, d));
      end
    end
  endtask

  task automatic test_blanking();
    logic ok;
    logic [31:0] fonts;
    test_conversion(7, 4'b0000, "blank");
    i_dp = 4'b0010;
    capture_fonts(fonts, ok);
    checks++;
    if (!ok || fonts[15:8] !== exp_font(7, 4'b0010, 1)) begin
      failures++; $display("FAIL blank_tens_dp got=%h exp=%h", fonts[15:8], exp_font(7, 4'b0010, 1));
    end
    i_dp = 4'b0000;
  endtask

  task automatic test_reset_mid_conversion();
    int cnt;
    logic ok;
    logic [31:0] fonts;
    i_dp = 4'b0000;
    @(negedge clk);
    i_value = 14'd9876;
    i_load  = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    checks++; if (o_fndFont !== 8'hC0) begin failures++; $display("FAIL midrst_font got=%h exp=c0", o_fndFont); end
    @(negedge clk);
    rst_n = 1'b1;
    capture_fonts(fonts, ok);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!ok || fonts[d*8 +: 8] !== exp_font(0, 4'b0000, d)) begin
        failures++; $display("FAIL midrst_digit%0d got=%h exp=%h", d, fonts[d*8 +: 8], exp_font(0, 4'b0000, d));
      end
    end
    // load already asserted on the first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    i_value = 14'd9876;
    i_load  = 1'b1;
    rst_n   = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL rel_load_busy got=%b exp=1", o_busy); end
    cnt = 0;
    while (o_busy && cnt < 40) begin cnt++; @(negedge clk); end
    checks++; if (cnt !== 15) begin failures++; $display("FAIL rel_load_len got=%0d exp=15", cnt); end
    capture_fonts(fonts, ok);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!ok || fonts[d*8 +: 8] !== exp_font(9876, 4'b0000, d)) begin
        failures++; $display("FAIL rel_load_digit%0d got=%h exp=%h", d, fonts[d*8 +: 8], exp_font(9876, 4'b0000, d));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_conversion(1234, 4'b0000, "conv1234");
    test_conversion(12000, 4'b0000, "clamp");
    test_conversion(9999, 4'b1010, "max");
    test_ignored_load();
    test_blanking();
    test_random();
    test_reset_mid_conversion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
